// File: rtl/fp_linear_decoder_if.sv
// Operand/result handshake bundle for fp_linear_decoder: S/E/F in with
// in_valid/in_ready, linear result D out with out_valid/out_ready.
interface fp_linear_decoder_if #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [SIG_W-1:0] F;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] D;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D
  );
endinterface

// File: rtl/fp_linear_decoder.sv
// Sign/exponent/significand to two's-complement linear decoder, D = (-1)^S * F * 2^E.
// Iterative one-shift-per-clock datapath; define FPDEC_BARREL_EN for a single-cycle barrel shifter.
module fp_linear_decoder #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input logic              clk,
  input logic              rst_n,
  fp_linear_decoder_if.slave bus
);

`ifdef FPDEC_BARREL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_HOLD = 2'd2} state_e;
`endif

  state_e           state_r, state_n;
  logic [OUT_W-1:0] d_r, d_n;
  logic             out_valid_r, out_valid_n;
  logic             in_ready_r;
  logic             accept_s;
`ifdef FPDEC_BARREL_EN
  logic [OUT_W-1:0] mag_bar_s;
`else
  logic [OUT_W-1:0] mag_r, mag_n;
  logic [EXP_W-1:0] cnt_r, cnt_n;
  logic             sgn_r, sgn_n;
`endif

  assign accept_s      = bus.in_valid & in_ready_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.D         = d_r;
`ifdef FPDEC_BARREL_EN
  assign mag_bar_s     = OUT_W'(bus.F) << bus.E;
`endif

  // State and datapath registers; in_ready is registered as the decode of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      d_r         <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
`ifndef FPDEC_BARREL_EN
      mag_r       <= {OUT_W{1'b0}};
      cnt_r       <= {EXP_W{1'b0}};
      sgn_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      d_r         <= d_n;
      out_valid_r <= out_valid_n;
      in_ready_r  <= (state_n == ST_IDLE);
`ifndef FPDEC_BARREL_EN
      mag_r       <= mag_n;
      cnt_r       <= cnt_n;
      sgn_r       <= sgn_n;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state_r;
    d_n         = d_r;
    out_valid_n = out_valid_r;
`ifndef FPDEC_BARREL_EN
    mag_n       = mag_r;
    cnt_n       = cnt_r;
    sgn_n       = sgn_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef FPDEC_BARREL_EN
          d_n         = bus.S ? (~mag_bar_s + OUT_W'(1'b1)) : mag_bar_s;
          out_valid_n = 1'b1;
          state_n     = ST_HOLD;
`else
          mag_n   = OUT_W'(bus.F);
          cnt_n   = bus.E;
          sgn_n   = bus.S;
          state_n = ST_SHIFT;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
`ifndef FPDEC_BARREL_EN
      // F=0 negates to 0, so no negative zero can appear.
      ST_SHIFT: begin
        if (cnt_r != {EXP_W{1'b0}}) begin
          mag_n = {mag_r[OUT_W-2:0], 1'b0};
          cnt_n = cnt_r - EXP_W'(1'b1);
        end else begin
          d_n         = sgn_r ? (~mag_r + OUT_W'(1'b1)) : mag_r;
          out_valid_n = 1'b1;
          state_n     = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        out_valid_n = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_linear_decoder.sv
// Self-checking bench for fp_linear_decoder: directed table, back-pressure and
// mid-operation reset sequences, plus an exhaustive S/E/F sweep with random hold times.
module tb_fp_linear_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_linear_decoder_if #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) bus ();

  fp_linear_decoder #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    logic [11:0] d;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic, truncated to the 12-bit output.
  function automatic logic [11:0] model(input int s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s != 0) v = -v;
    return 12'(v);
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int exp_lat(input int e);
`ifdef FPDEC_BARREL_EN
    return 0 + (e * 0);
`else
    return e + 1;
`endif
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic do_op(input logic s, input logic [2:0] e, input logic [3:0] f,
                       input int hold, input logic [11:0] exp_d);
    int lat;
    wait_ready();
    bus.S = s; bus.E = e; bus.F = f;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble operands: only the accept edge may sample them.
    bus.S = 1'($urandom); bus.E = 3'($urandom); bus.F = 4'($urandom);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(exp_lat(int'(e))));
    chk("d", 32'(bus.D), 32'(exp_d));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_d", 32'(bus.D), 32'(exp_d));
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    vecs[0] = '{1'b0, 3'd0, 4'hA, 12'h00A};
    vecs[1] = '{1'b1, 3'd3, 4'hF, 12'hF88};
    vecs[2] = '{1'b0, 3'd7, 4'hF, 12'h780};
    vecs[3] = '{1'b1, 3'd7, 4'hF, 12'h880};
    vecs[4] = '{1'b1, 3'd5, 4'h0, 12'h000};
    vecs[5] = '{1'b0, 3'd2, 4'h3, 12'h00C};
    vecs[6] = '{1'b1, 3'd0, 4'h1, 12'hFFF};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.S = 1'b0; bus.E = 3'd0; bus.F = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_d", 32'(bus.D), 32'd0);
    chk("reset_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].s, vecs[i].e, vecs[i].f, 0, vecs[i].d);

    // Back-pressure: result held while a new operand waits on in_valid.
    wait_ready();
    bus.S = 1'b0; bus.E = 3'd0; bus.F = 4'hA;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.S = 1'b1; bus.E = 3'd2; bus.F = 4'd3;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'(exp_lat(0)));
    chk("bp_d", 32'(bus.D), 32'h00A);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_d", 32'(bus.D), 32'h00A);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_taken", 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    chk("bp2_lat", 32'(lat), 32'(exp_lat(2)));
    chk("bp2_d", 32'(bus.D), 32'hFF4);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp2_release", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of an E=7 operation discards it.
    wait_ready();
    bus.S = 1'b0; bus.E = 3'd7; bus.F = 4'hF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_d", 32'(bus.D), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // Exhaustive sweep with random output back-pressure.
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 8; e++)
        for (int f = 0; f < 16; f++)
          do_op(1'(s), 3'(e), 4'(f), int'($urandom_range(0, 2)), model(s, e, f));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
